// File: rtl/la_uart_dump.sv
// Sample-buffer readout: walks every buffer address and streams a framed dump
// (A5 5A trigHi trigLo samples... checksum) out of an 8N1 UART transmitter.
module la_uart_dump #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 11,
    parameter int CLK_DIV    = 434
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  capture_done,
    input  logic                  dump_req,
    input  logic [ADDR_WIDTH-1:0] trigger_index,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  uart_tx,
    output logic                  busy,
    output logic                  dump_done
);

    localparam int                 BAUD_W      = $clog2(CLK_DIV);
    localparam logic [BAUD_W-1:0]  BAUD_RELOAD = BAUD_W'(CLK_DIV - 1);
    localparam logic [ADDR_WIDTH:0] LAST_CNT   = {1'b0, {ADDR_WIDTH{1'b1}}};

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        RD_ADDR,
        RD_WAIT,
        SEND,
        CHK,
        DONE
    } state_t;

    state_t                r_state;
    logic                  r_capD;
    logic [ADDR_WIDTH-1:0] r_trig;
    logic [7:0]            r_chk;
    logic [1:0]            r_hdrIdx;
    logic [ADDR_WIDTH:0]   r_cnt;
    logic [8:0]            r_shift;
    logic [3:0]            r_bitCnt;
    logic [BAUD_W-1:0]     r_baudCnt;
    logic                  r_txBusy;

    logic                  w_start;
    logic                  w_txLast;
    logic                  w_loadEn;
    logic [7:0]            w_loadByte;
    logic [7:0]            w_hdrByte;
    logic [15:0]           w_trig16;

    assign w_start  = dump_req | (capture_done & ~r_capD);
    assign w_txLast = r_txBusy && (r_baudCnt == '0) && (r_bitCnt == 4'd0);
    assign w_trig16 = 16'(r_trig);

    // Header byte that follows the one currently on the line.
    always_comb begin
        case (r_hdrIdx)
            2'd0:    w_hdrByte = 8'h5A;
            2'd1:    w_hdrByte = w_trig16[15:8];
            default: w_hdrByte = w_trig16[7:0];
        endcase
    end

    // A new byte is loaded on the same edge the previous stop bit ends, so
    // header and checksum bytes follow back-to-back.
    always_comb begin
        w_loadEn   = 1'b0;
        w_loadByte = 8'h00;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_loadEn   = 1'b1;
                    w_loadByte = 8'hA5;
                end
            end
            HDR: begin
                if (w_txLast && (r_hdrIdx != 2'd3)) begin
                    w_loadEn   = 1'b1;
                    w_loadByte = w_hdrByte;
                end
            end
            RD_WAIT: begin
                w_loadEn   = 1'b1;
                w_loadByte = 8'(rd_data);
            end
            SEND: begin
                if (w_txLast && (r_cnt == LAST_CNT)) begin
                    w_loadEn   = 1'b1;
                    w_loadByte = r_chk;
                end
            end
            default: begin
                w_loadEn   = 1'b0;
                w_loadByte = 8'h00;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state   <= IDLE;
            r_capD    <= 1'b0;
            r_trig    <= '0;
            r_chk     <= 8'h00;
            r_hdrIdx  <= 2'd0;
            r_cnt     <= '0;
            r_shift   <= 9'h1FF;
            r_bitCnt  <= 4'd0;
            r_baudCnt <= '0;
            r_txBusy  <= 1'b0;
            rd_addr   <= '0;
            uart_tx   <= 1'b1;
            busy      <= 1'b0;
            dump_done <= 1'b0;
        end else begin
            r_capD    <= capture_done;
            dump_done <= 1'b0;

            // Shifter: start bit on load, then 9 more bits (data LSB-first, stop).
            if (w_loadEn) begin
                uart_tx   <= 1'b0;
                r_shift   <= {1'b1, w_loadByte};
                r_bitCnt  <= 4'd9;
                r_baudCnt <= BAUD_RELOAD;
                r_txBusy  <= 1'b1;
            end else if (r_txBusy) begin
                if (r_baudCnt != '0) begin
                    r_baudCnt <= r_baudCnt - 1'b1;
                end else if (r_bitCnt != 4'd0) begin
                    uart_tx   <= r_shift[0];
                    r_shift   <= {1'b1, r_shift[8:1]};
                    r_bitCnt  <= r_bitCnt - 4'd1;
                    r_baudCnt <= BAUD_RELOAD;
                end else begin
                    r_txBusy <= 1'b0;
                end
            end

            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_trig   <= trigger_index;
                        r_chk    <= 8'h00;
                        r_hdrIdx <= 2'd0;
                        busy     <= 1'b1;
                        r_state  <= HDR;
                    end
                end
                HDR: begin
                    if (w_txLast) begin
                        if (r_hdrIdx == 2'd3) begin
                            r_cnt   <= '0;
                            rd_addr <= '0;
                            r_state <= RD_ADDR;
                        end else begin
                            r_hdrIdx <= r_hdrIdx + 2'd1;
                        end
                    end
                end
                RD_ADDR: r_state <= RD_WAIT;
                RD_WAIT: begin
                    r_chk   <= r_chk + 8'(rd_data);
                    r_state <= SEND;
                end
                SEND: begin
                    if (w_txLast) begin
                        if (r_cnt == LAST_CNT) begin
                            r_state <= CHK;
                        end else begin
                            r_cnt   <= r_cnt + 1'b1;
                            rd_addr <= r_cnt[ADDR_WIDTH-1:0] + 1'b1;
                            r_state <= RD_ADDR;
                        end
                    end
                end
                CHK: begin
                    if (w_txLast) begin
                        busy      <= 1'b0;
                        dump_done <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
